// File: rtl/mmio_uart_tx_pkg.sv
// ---------------------------------------------------------------------------
// mmio_uart_tx_pkg
// Shared definitions for the memory-mapped UART transmitter:
//   - CPU memory-bus command encodings (MREAD / MWRITE)
//   - transmit FSM state encoding (2-bit: IDLE=0, START=1, DATA=2, STOP=3)
//   - bit positions of the fields in the status word
// ---------------------------------------------------------------------------
package mmio_uart_tx_pkg;

    localparam logic [1:0] MREAD  = 2'b01;
    localparam logic [1:0] MWRITE = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_e;

    // Status word layout; count occupies [FIFO_AW+4:4], everything else 0.
    localparam int STAT_FULL   = 0;
    localparam int STAT_EMPTY  = 1;
    localparam int STAT_ACTIVE = 2;
    localparam int STAT_OVF    = 3;
    localparam int STAT_COUNT  = 4;

endpackage

// File: rtl/mmio_uart_tx_fifo.sv
// ---------------------------------------------------------------------------
// uart_tx_fifo
// Byte FIFO feeding the UART serializer. Depth 2**FIFO_AW, head is
// presented combinationally on dout.
//   clk, reset  : clock, asynchronous active-high reset (pointers/count)
//   push, din   : enqueue request and byte; accepted when not full, or when
//                 a pop happens on the same edge
//   pop         : dequeue request (ignored when empty)
//   dout        : current head byte
//   full, empty : occupancy flags
//   count       : occupancy, 0..2**FIFO_AW
// ---------------------------------------------------------------------------
module uart_tx_fifo #(
    parameter int FIFO_AW = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               push,
    input  logic               pop,
    input  logic [7:0]         din,
    output logic [7:0]         dout,
    output logic               full,
    output logic               empty,
    output logic [FIFO_AW:0]   count
);

    localparam int                DEPTH   = 2 ** FIFO_AW;
    localparam logic [FIFO_AW:0]  DEPTH_C = (FIFO_AW + 1)'(DEPTH);

    logic [7:0]         r_mem [DEPTH];
    logic [FIFO_AW-1:0] r_wptr;
    logic [FIFO_AW-1:0] r_rptr;
    logic [FIFO_AW:0]   r_count;

    logic w_do_push;
    logic w_do_pop;

    assign full  = (r_count == DEPTH_C);
    assign empty = (r_count == '0);
    assign count = r_count;
    assign dout  = r_mem[r_rptr];

    // When full, a simultaneous pop frees the head slot, which is exactly the
    // slot r_wptr points at; the head is read before the edge, so the write
    // into it on the same edge is safe.
    assign w_do_pop  = pop & ~empty;
    assign w_do_push = push & (~full | w_do_pop);

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wptr] <= din;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/mmio_uart_tx.sv
// ---------------------------------------------------------------------------
// mmio_uart_tx
// Memory-mapped 8N1 UART transmitter on the CPU memory-command bus.
//   clk, reset  : system clock, asynchronous active-high reset
//   mem_cmd     : bus command (MREAD=01, MWRITE=10, others idle)
//   mem_addr    : bus address
//   write_data  : store data, [7:0] is the byte to transmit
//   read_data   : status word while a status read is selected, else high-Z
//   tx          : registered serial output, idle high
//   busy        : frame in progress or bytes waiting in the FIFO
// Stores to DATA_ADDR enqueue a byte (once per store, however long it is
// held); stores to STAT_ADDR clear the sticky overflow flag.
// ---------------------------------------------------------------------------
module mmio_uart_tx
    import mmio_uart_tx_pkg::*;
#(
    parameter logic [8:0] DATA_ADDR    = 9'h180,
    parameter logic [8:0] STAT_ADDR    = 9'h181,
    parameter int         CLKS_PER_BIT = 434,
    parameter int         FIFO_AW      = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  mem_cmd,
    input  logic [8:0]  mem_addr,
    input  logic [15:0] write_data,
    output logic [15:0] read_data,
    output logic        tx,
    output logic        busy
);

    localparam int                BAUD_W   = $clog2(CLKS_PER_BIT);
    localparam logic [BAUD_W-1:0] BAUD_TOP = BAUD_W'(CLKS_PER_BIT - 1);

    // Bus decode and edge qualification
    logic w_wsel, w_csel, w_rsel;
    logic r_wsel_q, r_csel_q;
    logic w_push, w_clr;
    logic r_ovf, w_ovf_set;

    // FIFO interface
    logic             w_pop;
    logic [7:0]       w_dout;
    logic             w_full, w_empty;
    logic [FIFO_AW:0] w_count;

    // Serializer state
    tx_state_e         r_state, w_state_nxt;
    logic [BAUD_W-1:0] r_baud, w_baud_nxt;
    logic [2:0]        r_bitidx, w_bitidx_nxt;
    logic [7:0]        r_shreg, w_shreg_nxt;
    logic              r_tx, w_tx_nxt;

    logic [15:0] w_status;
    logic        w_unused_wdata;

    assign w_unused_wdata = &{1'b0, write_data[15:8]};

    assign w_wsel = (mem_cmd == MWRITE) && (mem_addr == DATA_ADDR);
    assign w_csel = (mem_cmd == MWRITE) && (mem_addr == STAT_ADDR);
    assign w_rsel = (mem_cmd == MREAD)  && (mem_addr == STAT_ADDR);

    assign w_push = w_wsel & ~r_wsel_q;
    assign w_clr  = w_csel & ~r_csel_q;

    // A push into a full FIFO is only lost if nothing leaves on the same edge.
    assign w_ovf_set = w_push & w_full & ~w_pop;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wsel_q <= 1'b0;
            r_csel_q <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            r_wsel_q <= w_wsel;
            r_csel_q <= w_csel;
            if (w_ovf_set) begin
                r_ovf <= 1'b1;
            end else if (w_clr) begin
                r_ovf <= 1'b0;
            end
        end
    end

    uart_tx_fifo #(
        .FIFO_AW (FIFO_AW)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (w_push),
        .pop   (w_pop),
        .din   (write_data[7:0]),
        .dout  (w_dout),
        .full  (w_full),
        .empty (w_empty),
        .count (w_count)
    );

    always_comb begin
        w_status                                = '0;
        w_status[STAT_FULL]                     = w_full;
        w_status[STAT_EMPTY]                    = w_empty;
        w_status[STAT_ACTIVE]                   = (r_state != ST_IDLE);
        w_status[STAT_OVF]                      = r_ovf;
        w_status[STAT_COUNT +: FIFO_AW + 1]     = w_count;
    end

    assign read_data = w_rsel ? w_status : 16'bz;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_baud   <= '0;
            r_bitidx <= '0;
            r_shreg  <= '0;
            r_tx     <= 1'b1;
        end else begin
            r_state  <= w_state_nxt;
            r_baud   <= w_baud_nxt;
            r_bitidx <= w_bitidx_nxt;
            r_shreg  <= w_shreg_nxt;
            r_tx     <= w_tx_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_baud_nxt   = r_baud;
        w_bitidx_nxt = r_bitidx;
        w_shreg_nxt  = r_shreg;
        w_pop        = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_shreg_nxt = w_dout;
                    w_baud_nxt  = BAUD_TOP;
                    w_state_nxt = ST_START;
                end
            end
            ST_START: begin
                if (r_baud == '0) begin
                    w_baud_nxt   = BAUD_TOP;
                    w_bitidx_nxt = 3'd0;
                    w_state_nxt  = ST_DATA;
                end else begin
                    w_baud_nxt = r_baud - BAUD_W'(1);
                end
            end
            ST_DATA: begin
                if (r_baud == '0) begin
                    w_baud_nxt   = BAUD_TOP;
                    w_shreg_nxt  = {1'b0, r_shreg[7:1]};
                    w_bitidx_nxt = r_bitidx + 3'd1;
                    if (r_bitidx == 3'd7) begin
                        w_state_nxt = ST_STOP;
                    end
                end else begin
                    w_baud_nxt = r_baud - BAUD_W'(1);
                end
            end
            ST_STOP: begin
                if (r_baud == '0) begin
                    // Chain straight into the next start bit when data waits,
                    // so consecutive frames have no idle gap.
                    if (!w_empty) begin
                        w_pop       = 1'b1;
                        w_shreg_nxt = w_dout;
                        w_baud_nxt  = BAUD_TOP;
                        w_state_nxt = ST_START;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end else begin
                    w_baud_nxt = r_baud - BAUD_W'(1);
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase

        // Line level is decided from the state being entered so that tx is a
        // pure register output with the same timing as the state.
        case (w_state_nxt)
            ST_START: w_tx_nxt = 1'b0;
            ST_DATA:  w_tx_nxt = w_shreg_nxt[0];
            default:  w_tx_nxt = 1'b1;
        endcase
    end

    assign tx   = r_tx;
    assign busy = (r_state != ST_IDLE) | ~w_empty;

endmodule

// File: tb/tb_mmio_uart_tx.sv
module tb_mmio_uart_tx;

    localparam int         CPB    = 4;
    localparam int         FRAME  = 10 * CPB;
    localparam logic [1:0] CMD_RD = 2'b01;
    localparam logic [1:0] CMD_WR = 2'b10;
    localparam logic [8:0] A_DATA = 9'h180;
    localparam logic [8:0] A_STAT = 9'h181;
    localparam logic [15:0] ST_QUIET = 16'h0002;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  mem_cmd = 2'b00;
    logic [8:0]  mem_addr = 9'h000;
    logic [15:0] write_data = 16'h0000;
    wire  [15:0] read_data;
    wire         tx;
    wire         busy;

    always #5 clk = ~clk;

    mmio_uart_tx #(
        .DATA_ADDR    (A_DATA),
        .STAT_ADDR    (A_STAT),
        .CLKS_PER_BIT (CPB),
        .FIFO_AW      (2)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .mem_cmd    (mem_cmd),
        .mem_addr   (mem_addr),
        .write_data (write_data),
        .read_data  (read_data),
        .tx         (tx),
        .busy       (busy)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Scoreboard: bytes that must appear on the line, in order.
    logic [7:0] sb_q[$];

    // Line monitor state
    int   started     = 0;
    int   frames_seen = 0;
    int   b2b         = 0;
    int   mcyc        = 0;
    int   last_end    = -100;
    bit   in_frame    = 1'b0;
    int   mc          = 0;
    logic samp [FRAME];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic eval_frame();
        logic [7:0] d;
        logic [7:0] e;
        bit         steady;
        steady = 1'b1;
        for (int b = 0; b < 10; b++)
            for (int k = 1; k < CPB; k++)
                if (samp[b*CPB+k] !== samp[b*CPB]) steady = 1'b0;
        check("bit_timing", 32'(steady), 32'd1);
        check("start_stop", 32'({samp[0], samp[FRAME-1]}), 32'b01);
        for (int i = 0; i < 8; i++) d[i] = samp[(i+1)*CPB];
        if (sb_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_frame: got byte 0x%0h, expected no frame", d);
        end else begin
            e = sb_q.pop_front();
            check("frame_byte", 32'(d), 32'(e));
        end
    endtask

    // Line monitor: reconstructs frames from tx, one sample per clock.
    initial begin
        forever begin
            @(negedge clk);
            mcyc++;
            if (reset) begin
                in_frame = 1'b0;
            end else if (!in_frame) begin
                if (tx === 1'b0) begin
                    in_frame = 1'b1;
                    mc       = 0;
                    samp[0]  = tx;
                    started++;
                    if (mcyc == last_end + 1) b2b++;
                end
            end else begin
                mc++;
                samp[mc] = tx;
                if (mc == FRAME - 1) begin
                    in_frame = 1'b0;
                    last_end = mcyc;
                    frames_seen++;
                    eval_frame();
                end
            end
        end
    end

    task automatic bus_idle();
        mem_cmd    = 2'b00;
        mem_addr   = 9'h000;
        write_data = 16'h0000;
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Store held for 'hold' cycles, followed by one idle cycle.
    task automatic store(input logic [8:0] addr, input logic [7:0] data, input int hold);
        mem_cmd    = CMD_WR;
        mem_addr   = addr;
        write_data = {8'hC3, data};
        tick(hold);
        bus_idle();
        tick(1);
    endtask

    task automatic read_status(output logic [15:0] v);
        mem_cmd  = CMD_RD;
        mem_addr = A_STAT;
        #1;
        v = read_data;
        bus_idle();
        #1;
    endtask

    task automatic check_status(input string name, input logic [15:0] exp);
        logic [15:0] v;
        read_status(v);
        check(name, 32'(v), 32'(exp));
    endtask

    // Undriven bus: high-Z in a four-state simulator, zero in a two-state one.
    task automatic check_released(input string name);
        #1;
        check(name, 32'((read_data === 16'hzzzz) || (read_data === 16'h0000)), 32'd1);
        bus_idle();
        #1;
    endtask

    task automatic wait_drain(input string name, input int limit);
        int  n;
        bit  done;
        n    = 0;
        done = 1'b0;
        while (!done && n < limit) begin
            tick(1);
            n++;
            done = (sb_q.size() == 0) && !in_frame && (busy === 1'b0);
        end
        if (!done) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: drain timeout, %0d bytes outstanding, expected 0", name, sb_q.size());
        end
    endtask

    task automatic wait_mc(input string name, input int target);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            #1;
            n++;
        end while (!(in_frame && mc == target) && n < 200);
        if (!(in_frame && mc == target)) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: frame position %0d not reached, expected %0d", name, mc, target);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int          fs;
        int          pushed;
        int          n;
        logic [7:0]  b;

        // Reset state
        tick(3);
        check("rst_tx", 32'(tx), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        reset = 1'b0;
        tick(2);
        check_status("rst_status", ST_QUIET);
        check("idle_tx", 32'(tx), 32'd1);

        // Single byte 0xA5 with latency checks
        mem_cmd = CMD_WR; mem_addr = A_DATA; write_data = 16'h00A5;
        sb_q.push_back(8'hA5);
        tick(1);
        check("lat_tx_e0", 32'(tx), 32'd1);
        bus_idle();
        tick(1);
        check("lat_tx_e1", 32'(tx), 32'd0);
        check("busy_in_frame", 32'(busy), 32'd1);
        n = 0;
        while (frames_seen < 1 && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("single_frames", 32'(frames_seen), 32'd1);
        check("busy_last_stop", 32'(busy), 32'd1);
        @(negedge clk);
        #1;
        check("busy_after_stop", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        check_status("single_status", ST_QUIET);

        // Held store: one byte only
        fs = frames_seen;
        sb_q.push_back(8'h33);
        store(A_DATA, 8'h33, 5);
        check_status("held_status", 16'h0006);
        wait_drain("held", 300);
        check("held_frames", 32'(frames_seen - fs), 32'd1);

        // Fill and overflow, then back-to-back emission
        tick(3);
        b2b = 0;
        for (int v = 1; v <= 6; v++) begin
            if (v <= 5) sb_q.push_back(8'(v));
            store(A_DATA, 8'(v), 1);
        end
        check_status("fill_status", 16'h004D);
        store(A_STAT, 8'hFF, 1);
        check_status("ovf_clear", 16'h0045);
        wait_drain("fill", 600);
        check("back_to_back", 32'(b2b), 32'd4);
        check_status("fill_done", ST_QUIET);

        // Read select and bus isolation
        mem_cmd = CMD_RD; mem_addr = 9'h140;
        check_released("rd_other_addr");
        mem_cmd = 2'b00; mem_addr = A_STAT;
        check_released("rd_cmd_idle");
        mem_cmd = 2'b11; mem_addr = A_STAT;
        check_released("rd_cmd_11");
        fs = frames_seen;
        store(9'h100, 8'h5A, 1);
        store(A_STAT, 8'h5A, 1);
        tick(60);
        check("no_push_frames", 32'(frames_seen - fs), 32'd0);
        check_status("no_push_status", ST_QUIET);

        // Reset during data bit 3 with two bytes queued
        sb_q.push_back(8'h11);
        sb_q.push_back(8'h22);
        sb_q.push_back(8'h33);
        store(A_DATA, 8'h11, 1);
        store(A_DATA, 8'h22, 1);
        store(A_DATA, 8'h33, 1);
        wait_mc("rst_mid_pos", 17);
        reset = 1'b1;
        #1;
        check("rst_mid_tx", 32'(tx), 32'd1);
        check("rst_mid_busy", 32'(busy), 32'd0);
        sb_q.delete();
        @(posedge clk);
        @(negedge clk);
        #1;
        reset = 1'b0;
        tick(1);
        check_status("rst_mid_status", ST_QUIET);
        fs = frames_seen;
        tick(80);
        check("rst_no_resume", 32'(frames_seen - fs), 32'd0);
        check("rst_mid_line", 32'(tx), 32'd1);

        // Push on the exact edge STOP ends while full
        for (int v = 0; v < 6; v++) sb_q.push_back(8'hA0 + 8'(v));
        store(A_DATA, 8'hA0, 1);
        for (int v = 1; v < 5; v++) store(A_DATA, 8'hA0 + 8'(v), 1);
        wait_mc("edge_pos", 38);
        @(posedge clk);
        #1;
        mem_cmd = CMD_WR; mem_addr = A_DATA; write_data = 16'h00A5;
        tick(1);
        bus_idle();
        check_status("edge_push_status", 16'h0045);
        wait_drain("edge", 800);

        // Randomized traffic against the scoreboard
        tick(2);
        pushed = started;
        for (int k = 0; k < 40; k++) begin
            n = 0;
            while ((pushed - started) >= 4 && n < 400) begin
                tick(1);
                n++;
            end
            if ($urandom_range(0, 3) == 0) begin
                logic [8:0] a;
                a = 9'($urandom_range(0, 511));
                if (a == A_DATA || a == A_STAT) a = 9'h100;
                store(a, 8'($urandom), $urandom_range(1, 3));
            end
            b = 8'($urandom);
            sb_q.push_back(b);
            store(A_DATA, b, $urandom_range(1, 4));
            pushed++;
            tick($urandom_range(0, 15));
        end
        wait_drain("random", 4000);
        check_status("random_status", ST_QUIET);
        check("random_sb_empty", 32'(sb_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mmio_uart_tx.md
# mmio_uart_tx

Memory-mapped UART transmitter that answers the CPU's memory-command bus (`mem_cmd`/`mem_addr`/`write_data`/`read_data`) in the I/O window above RAM (`mem_addr[8]==1`), alongside the switch and LED blocks. CPU stores to the data address enqueue bytes into a small FIFO, and a serializer emits 8N1 frames on `tx`. CPU loads from the status address return FIFO and transmitter state on the shared, tri-stated `read_data` bus.

## Interface
Parameters:
- `DATA_ADDR`, default 9'h180: `MWRITE` here pushes `write_data[7:0]`.
- `STAT_ADDR`, default 9'h181: `MREAD` here returns status. `MWRITE` here clears overflow.
- `CLKS_PER_BIT`, default 434: clocks per bit (50 MHz / 115200). Must be ≥ 2.
- `FIFO_AW`, default 2: FIFO depth = 2**FIFO_AW (4).

Ports:
- Clock and reset: one clock; reset is asynchronous and active-high.
  - `clk`  in  1  system clock (CLOCK_50).
  - `reset`  in  1  asynchronous, active-high.
- `mem_cmd`  in  2  bus command: `MREAD`=2'b01, `MWRITE`=2'b10, other values idle.
- `mem_addr`  in  9  bus address.
- `write_data`  in  16  CPU store data. Only [7:0] is used.
- `read_data`  out  16  tri-state: driven only while status is selected, otherwise 16'bz.
- `tx`  out  1  serial line, idle high.
- `busy`  out  1  high while a frame is in progress or the FIFO is non-empty.

## Operation
- **Selects** (combinational):
  - `wsel = (mem_cmd==MWRITE && mem_addr==DATA_ADDR)`
  - `csel = (mem_cmd==MWRITE && mem_addr==STAT_ADDR)`
  - `rsel = (mem_cmd==MREAD && mem_addr==STAT_ADDR)`
- **Push is edge-qualified.** A registered `wsel_q` gives `push = wsel & ~wsel_q`. A store held for several cycles enqueues exactly once. The same rule applies to `csel`.
- **Push acceptance.** A push is accepted if the FIFO is not full, or if a pop occurs on the same edge. Otherwise the byte is dropped and sticky `ovf` is set.
- **Overflow clear.** `csel` edge clears `ovf`. If a clear and a new overflow occur on the same edge, set wins.
- **Status word**, driven when `rsel` (combinational, zero latency):
  - [0] full
  - [1] empty
  - [2] shifter active (state ≠ IDLE)
  - [3] ovf
  - [FIFO_AW+4:4] count
  - remaining bits 0
- **Transmit FSM** states: IDLE, START, DATA, STOP.
  - **IDLE:** `tx`=1. If the FIFO is non-empty: pop the head into `shreg`, load `baud = CLKS_PER_BIT-1`, go to START.
  - **START:** `tx`=0.
  - **DATA:** `tx = shreg[0]`, LSB first. `bitidx` runs 0..7.
  - **STOP:** `tx`=1.
  - **Bit timing (START/DATA/STOP):** `baud` decrements each clock. When `baud==0`, reload it and advance: START→DATA (`bitidx`=0); DATA shifts `shreg` right and increments `bitidx`, going to STOP after bit 7.
  - **End of STOP** (`baud==0`): if the FIFO is non-empty, pop and go directly to START (no idle gap); else go to IDLE.
- `tx` is registered: no glitches, no combinational path from the bus.
- **Reset (any time, including mid-frame):**
  - `tx`=1, `busy`=0.
  - FSM IDLE, `baud`=0, `bitidx`=0, `shreg`=0.
  - FIFO pointers and count 0, `ovf`=0, `wsel_q`/`csel_q`=0.
  - The aborted frame is not resumed.
  - `read_data` has no reset state; it depends only on `mem_cmd`/`mem_addr`.

## Timing
- Push at edge E into an empty FIFO with FSM IDLE:
  - the pop occurs at edge E+1;
  - `tx` falls after E+1.
- Every bit lasts exactly `CLKS_PER_BIT` cycles. A frame lasts 10·`CLKS_PER_BIT` cycles.
- Back-to-back frames: the next start bit begins on the cycle after the last stop-bit cycle.
- Status read reflects register state before the current edge. A push on the same cycle is visible on the next read.
- Count arithmetic: FIFO_AW+1 bits, range 0..2**FIFO_AW. Pointers are FIFO_AW bits and wrap modulo depth.
- Simultaneous push and pop:
  - when full: both occur, count unchanged, no overflow;
  - when empty: the pop cannot occur (FSM sees empty); the push lands.

## Structure
- Shared include `mem_cmd_defs.vh` holds `MREAD`/`MWRITE` (currently defined inline at top level) and the UART state encodings (2-bit: IDLE=0, START=1, DATA=2, STOP=3).
- Sub-module `uart_tx_fifo` (params FIFO_AW, width 8):
  - inputs `push`/`pop`/`din`
  - outputs `dout` (head, combinational), `full`, `empty`, `count`
  - asynchronous reset
- Top `mmio_uart_tx`: select/edge logic, status mux with tri-state, FSM/baud/shift datapath.
- Top-level integration: connect `read_data` to the shared bus; map `tx` to a GPIO pin.

## Test plan
All scenarios use `CLKS_PER_BIT`=4 and `FIFO_AW`=2.
- **Single byte.** Reset, then one-cycle `MWRITE` 0x0A5 to 0x180. Required: `tx` = 0,1,0,1,0,0,1,0,1,1, each level held 4 cycles (40 cycles total); `busy` falls after the stop bit; then status read = 0x0002.
- **Held store.** `MWRITE` 0x180 held 5 cycles with data 0x33. Required: exactly one frame sent, count never exceeds 1.
- **Fill and overflow.** Write 0x01..0x06 as separated single-cycle stores during the first frame. Required: 0x01 is popped and in flight, 0x02..0x05 are queued, 0x06 is dropped; status = full|active|ovf|count 4 = 0x004D; frames 01..05 are emitted back-to-back with no idle gap; `MWRITE` to 0x181 then clears bit 3.
- **Read and bus isolation.** `MREAD` 0x181 drives `read_data`. `MREAD` 0x140 and `mem_cmd`=0 leave `read_data` at 16'bz. `MWRITE` to 0x100 causes no push.
- **Reset mid-frame.** Assert `reset` during data bit 3 with 2 bytes queued. Required: `tx`=1 and `busy`=0 immediately (asynchronous); status 0x0002 after release; no frame resumes.
- **Push at pop edge.** With the FIFO full, push on the exact cycle STOP ends. Required: no overflow, count stays 4.
